// File: rtl/stream_delay_arbiter_pkg.sv
// Shared types and helpers for the delayed round-robin stream arbiter.
package stream_delay_arbiter_pkg;

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_LOAD,
        CNT_DEC
    } cnt_op_e;

    // Index width never collapses to zero, so a single input still has a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_delay_arbiter_counter.sv
// Loadable down-counter used to time the hold-off between grant and offer.
module stream_delay_arbiter_counter
    import stream_delay_arbiter_pkg::*;
#(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  cnt_op_e          op_i,
    input  logic [Width-1:0] load_val_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            case (op_i)
                CNT_LOAD: count_q <= load_val_i;
                CNT_DEC:  count_q <= count_q - Width'(1);
                default:  count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/stream_delay_arbiter.sv
// Round-robin N:1 stream arbiter that holds each grant for a configurable
// number of cycles before offering the winner's payload downstream.
module stream_delay_arbiter
    import stream_delay_arbiter_pkg::*;
#(
    parameter int unsigned NumInp     = 4,
    parameter int unsigned DelayWidth = 4,
    parameter type         payload_t  = logic,
    localparam int unsigned IdxW      = idx_width(NumInp)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DelayWidth-1:0] cfg_delay_i,
    input  logic [NumInp-1:0]     inp_valid_i,
    output logic [NumInp-1:0]     inp_ready_o,
    input  payload_t [NumInp-1:0] inp_data_i,
    output logic                  oup_valid_o,
    input  logic                  oup_ready_i,
    output payload_t              oup_data_o,
    output logic [IdxW-1:0]       oup_idx_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        SERVE
    } state_e;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumInp - 1);

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [IdxW-1:0]       rr_q, rr_d;
    logic [IdxW-1:0]       sel;
    logic [IdxW-1:0]       cur_idx;
    logic                  any_valid;
    logic                  offer;
    logic                  handshake;
    cnt_op_e               cnt_op;
    logic [DelayWidth-1:0] cnt_load;
    logic [DelayWidth-1:0] cnt_val;

    assign any_valid = |inp_valid_i;

    // First requesting input at or after rr_q, wrapping past the last input.
    always_comb begin : rr_select
        int   j;
        logic found;
        j     = 0;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < int'(NumInp); k++) begin
            j = int'(rr_q) + k;
            if (j >= int'(NumInp)) begin
                j = j - int'(NumInp);
            end
            if (!found && inp_valid_i[IdxW'(j)]) begin
                sel   = IdxW'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin : fsm_next
        state_d   = state_q;
        idx_d     = idx_q;
        rr_d      = rr_q;
        cnt_op    = CNT_HOLD;
        cnt_load  = cfg_delay_i - DelayWidth'(1);
        offer     = 1'b0;
        cur_idx   = idx_q;
        handshake = 1'b0;

        unique case (state_q)
            IDLE: begin
                cur_idx = any_valid ? sel : '0;
                if (any_valid) begin
                    idx_d = sel;
                    if (cfg_delay_i == '0) begin
                        // Zero hold-off: offer in the same cycle as the grant.
                        offer   = 1'b1;
                        state_d = SERVE;
                    end else if (cfg_delay_i == DelayWidth'(1)) begin
                        state_d = SERVE;
                    end else begin
                        cnt_op  = CNT_LOAD;
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                if (cnt_val == DelayWidth'(1)) begin
                    state_d = SERVE;
                end else begin
                    cnt_op = CNT_DEC;
                end
            end
            SERVE: begin
                offer = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        handshake = offer && inp_valid_i[cur_idx] && oup_ready_i && !rst_i;
        if (handshake) begin
            state_d = IDLE;
            rr_d    = (cur_idx == LastIdx) ? '0 : cur_idx + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
        end
    end

    stream_delay_arbiter_counter #(
        .Width(DelayWidth)
    ) u_delay_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .op_i       (cnt_op),
        .load_val_i (cnt_load),
        .count_o    (cnt_val)
    );

    // Outputs are forced quiet while reset is held, even before the first edge.
    always_comb begin : ready_fanout
        inp_ready_o = '0;
        if (offer && !rst_i) begin
            inp_ready_o[cur_idx] = oup_ready_i;
        end
    end

    assign oup_valid_o = offer && inp_valid_i[cur_idx] && !rst_i;
    assign oup_data_o  = inp_data_i[cur_idx];
    assign oup_idx_o   = rst_i ? '0 : cur_idx;
    assign busy_o      = (state_q != IDLE) && !rst_i;

    // Once offered without acceptance, the granted source must keep valid up.
    granted_valid_held: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (oup_valid_o && !oup_ready_i) |=> oup_valid_o
    );

endmodule
